// File: rtl/btn_filter_bank.sv
// Multi-channel button conditioner: per-channel synchroniser, stable-count debounce,
// press/release strobes and an optional hold-to-repeat strobe.
module btn_filter_bank #(
  parameter int                  CHANNELS      = 4,
  parameter int                  STABLE_CYCLES = 16,
  parameter int                  SYNC_STAGES   = 2,
  parameter logic [CHANNELS-1:0] INPUT_INVERT  = '0,
  parameter int                  REPEAT_DELAY  = 0,
  parameter int                  REPEAT_PERIOD = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] rawButtons,
  output logic [CHANNELS-1:0] filteredButtons,
  output logic [CHANNELS-1:0] pressPulse,
  output logic [CHANNELS-1:0] releasePulse,
  output logic [CHANNELS-1:0] repeatPulse
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic [SYNC_STAGES-1:0] sync_q, sync_d;
      logic [CNT_W-1:0]       cnt_q, cnt_d;
      logic                   filt_q, filt_d;
      logic                   press_q, press_d;
      logic                   rel_q, rel_d;
      logic                   synced;
      logic                   flip;

      assign synced = sync_q[SYNC_STAGES-1];

      // Any sample agreeing with the current level restarts qualification.
      always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], rawButtons[gi] ^ INPUT_INVERT[gi]};
        cnt_d  = cnt_q;
        filt_d = filt_q;
        flip   = 1'b0;
        if (synced == filt_q) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
          filt_d = synced;
          cnt_d  = '0;
          flip   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        press_d = flip & synced;
        rel_d   = flip & ~synced;
      end

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          sync_q  <= '0;
          cnt_q   <= '0;
          filt_q  <= 1'b0;
          press_q <= 1'b0;
          rel_q   <= 1'b0;
        end else begin
          sync_q  <= sync_d;
          cnt_q   <= cnt_d;
          filt_q  <= filt_d;
          press_q <= press_d;
          rel_q   <= rel_d;
        end
      end

      assign filteredButtons[gi] = filt_q;
      assign pressPulse[gi]      = press_q;
      assign releasePulse[gi]    = rel_q;

      if ((REPEAT_DELAY > 0) && (REPEAT_PERIOD > 0)) begin : g_rpt
        localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
        localparam int RPT_W   = $clog2(RPT_MAX + 1);

        logic [RPT_W-1:0] rcnt_q, rcnt_d;
        logic             period_q, period_d;
        logic             rpt_q, rpt_d;

        // Cleared while released and on the press/release edges; period_q marks
        // that the initial delay has elapsed and the counter now wraps on the period.
        always_comb begin
          rcnt_d   = rcnt_q;
          period_d = period_q;
          rpt_d    = 1'b0;
          if (!filt_q || flip) begin
            rcnt_d   = '0;
            period_d = 1'b0;
          end else if (!period_q) begin
            if (rcnt_q == RPT_W'(REPEAT_DELAY - 1)) begin
              rpt_d    = 1'b1;
              rcnt_d   = '0;
              period_d = 1'b1;
            end else begin
              rcnt_d = rcnt_q + 1'b1;
            end
          end else begin
            if (rcnt_q == RPT_W'(REPEAT_PERIOD - 1)) begin
              rpt_d  = 1'b1;
              rcnt_d = '0;
            end else begin
              rcnt_d = rcnt_q + 1'b1;
            end
          end
        end

        always_ff @(posedge clock or posedge reset) begin
          if (reset) begin
            rcnt_q   <= '0;
            period_q <= 1'b0;
            rpt_q    <= 1'b0;
          end else begin
            rcnt_q   <= rcnt_d;
            period_q <= period_d;
            rpt_q    <= rpt_d;
          end
        end

        assign repeatPulse[gi] = rpt_q;
      end else begin : g_no_rpt
        assign repeatPulse[gi] = 1'b0;
      end
    end
  endgenerate

endmodule
